// File: rtl/l1_pkg.sv
// Shared types, default sizes and helpers for the L1 miss/refill engine.
package l1_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} l1_refill_state_t;

  localparam int unsigned L1_WAY_NUM = 4;
  localparam int unsigned L1_IDX_W   = 5;
  localparam int unsigned L1_TAG_W   = 22;
  localparam int unsigned L1_BEAT_W  = 32;
  localparam int unsigned L1_BEATS   = 4;

  // Widest way vector the helper below handles.
  localparam int unsigned L1_VEC_MAX = 32;

  // Keeps only the lowest set bit; an all-zero input maps to bit 0.
  function automatic logic [L1_VEC_MAX-1:0] lowest_one_hot(input logic [L1_VEC_MAX-1:0] vec);
    logic [L1_VEC_MAX-1:0] res;
    res = vec & (~vec + L1_VEC_MAX'(1));
    if (vec == '0) begin
      res = L1_VEC_MAX'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_refill_ctrl.sv
// L1 miss-handling engine: line read request, beat-by-beat data writes, tag/valid commit.
// Optional sticky protocol error output enabled by defining L1_REFILL_ERR_CHK_EN.
module l1_refill_ctrl
  import l1_pkg::*;
#(
  parameter int unsigned WAY_NUM = L1_WAY_NUM,
  parameter int unsigned IDX_W   = L1_IDX_W,
  parameter int unsigned TAG_W   = L1_TAG_W,
  parameter int unsigned BEAT_W  = L1_BEAT_W,
  parameter int unsigned BEATS   = L1_BEATS,
  localparam int unsigned CNT_W  = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [IDX_W-1:0]       miss_idx,
  input  logic [TAG_W-1:0]       miss_tag,
  input  logic [WAY_NUM-1:0]     miss_way,
  output logic                   miss_ack,
  output logic                   busy,
  output logic                   mem_req_val,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr,
  input  logic                   mem_req_rdy,
  input  logic                   mem_ack_val,
  input  logic [BEAT_W-1:0]      mem_ack_data,
  output logic                   data_we,
  output logic [WAY_NUM-1:0]     data_way,
  output logic [IDX_W-1:0]       data_idx,
  output logic [CNT_W-1:0]       data_beat,
  output logic [BEAT_W-1:0]      data_wdata,
  output logic                   tag_we,
  output logic [TAG_W-1:0]       tag_wdata,
`ifdef L1_REFILL_ERR_CHK_EN
  output logic                   err,
`endif
  output logic                   refill_done
);

  l1_refill_state_t   state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WAY_NUM-1:0] way_q, way_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]  wdata_q, wdata_d;
  logic [WAY_NUM-1:0] way_norm;

  assign way_norm = WAY_NUM'(lowest_one_hot(L1_VEC_MAX'(miss_way)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    way_d   = way_q;
    we_d    = 1'b0;
    beat_d  = beat_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (miss_req) begin
          idx_d   = miss_idx;
          tag_d   = miss_tag;
          way_d   = way_norm;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_rdy) begin
          state_d = FILL;
        end
      end
      FILL: begin
        // Beat is registered here; its array write appears on the next cycle.
        if (mem_ack_val) begin
          we_d    = 1'b1;
          beat_d  = cnt_q;
          wdata_d = mem_ack_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
    end
  end

  // Gated by rst so every output reads 0 while reset is held.
  assign miss_ack     = miss_req & (state_q == IDLE) & ~rst;
  assign busy         = (state_q != IDLE);
  assign mem_req_val  = (state_q == REQ);
  assign mem_req_addr = {tag_q, idx_q};
  assign data_we      = we_q;
  assign data_way     = way_q;
  assign data_idx     = idx_q;
  assign data_beat    = beat_q;
  assign data_wdata   = wdata_q;
  assign tag_we       = (state_q == COMMIT);
  assign tag_wdata    = tag_q;
  assign refill_done  = (state_q == COMMIT);

`ifdef L1_REFILL_ERR_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && miss_req && !$onehot(miss_way)) begin
      err_d = 1'b1;
    end
    if (((state_q == IDLE) || (state_q == REQ)) && mem_ack_val) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Self-checking bench for l1_refill_ctrl: directed cases then randomized misses vs. a line model.
module tb_l1_refill_ctrl;
  import l1_pkg::*;

  localparam int unsigned WAY_NUM = 4;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned TAG_W   = 22;
  localparam int unsigned BEAT_W  = 32;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned CNT_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   miss_req;
  logic [IDX_W-1:0]       miss_idx;
  logic [TAG_W-1:0]       miss_tag;
  logic [WAY_NUM-1:0]     miss_way;
  logic                   miss_ack;
  logic                   busy;
  logic                   mem_req_val;
  logic [TAG_W+IDX_W-1:0] mem_req_addr;
  logic                   mem_req_rdy;
  logic                   mem_ack_val;
  logic [BEAT_W-1:0]      mem_ack_data;
  logic                   data_we;
  logic [WAY_NUM-1:0]     data_way;
  logic [IDX_W-1:0]       data_idx;
  logic [CNT_W-1:0]       data_beat;
  logic [BEAT_W-1:0]      data_wdata;
  logic                   tag_we;
  logic [TAG_W-1:0]       tag_wdata;
  logic                   refill_done;
`ifdef L1_REFILL_ERR_CHK_EN
  logic                   err;
`endif

  l1_refill_ctrl #(
    .WAY_NUM(WAY_NUM), .IDX_W(IDX_W), .TAG_W(TAG_W), .BEAT_W(BEAT_W), .BEATS(BEATS)
  ) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_idx(miss_idx), .miss_tag(miss_tag), .miss_way(miss_way),
    .miss_ack(miss_ack), .busy(busy),
    .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
    .mem_ack_val(mem_ack_val), .mem_ack_data(mem_ack_data),
    .data_we(data_we), .data_way(data_way), .data_idx(data_idx), .data_beat(data_beat),
    .data_wdata(data_wdata), .tag_we(tag_we), .tag_wdata(tag_wdata),
`ifdef L1_REFILL_ERR_CHK_EN
    .err(err),
`endif
    .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int n_done = 0;

  // Observed array/tag writes, logged mid-cycle.
  logic [CNT_W-1:0]   we_beat[$];
  logic [BEAT_W-1:0]  we_data[$];
  logic [WAY_NUM-1:0] we_way[$];
  logic [IDX_W-1:0]   we_idx[$];
  logic [TAG_W-1:0]   tg_tag[$];
  logic [WAY_NUM-1:0] tg_way[$];
  logic [IDX_W-1:0]   tg_idx[$];
  logic [BEAT_W-1:0]  exp_q[$];

  always @(negedge clk) begin
    if (data_we) begin
      we_beat.push_back(data_beat);
      we_data.push_back(data_wdata);
      we_way.push_back(data_way);
      we_idx.push_back(data_idx);
    end
    if (tag_we) begin
      tg_tag.push_back(tag_wdata);
      tg_way.push_back(data_way);
      tg_idx.push_back(data_idx);
    end
    if (refill_done) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    we_beat.delete(); we_data.delete(); we_way.delete(); we_idx.delete();
    tg_tag.delete(); tg_way.delete(); tg_idx.delete(); exp_q.delete();
    n_done = 0;
  endtask

  // Victim way the cache should actually use: first set bit, or way 0 if none.
  function automatic logic [WAY_NUM-1:0] ref_way(input logic [WAY_NUM-1:0] w);
    for (int i = 0; i < int'(WAY_NUM); i++) begin
      if (w[i]) return WAY_NUM'(1) << i;
    end
    return WAY_NUM'(1);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({miss_ack, busy, mem_req_val, data_we, tag_we, refill_done}), 64'd0);
    check({tag, "_addr"}, 64'(mem_req_addr), 64'd0);
    check({tag, "_wpos"}, 64'({data_way, data_idx, data_beat}), 64'd0);
    check({tag, "_wdata"}, 64'(data_wdata), 64'd0);
    check({tag, "_tagw"}, 64'(tag_wdata), 64'd0);
  endtask

  task automatic do_miss(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [WAY_NUM-1:0] way, input int rdy_wait, input int gap,
                         input bit stray, input bit fixed, input bit hold,
                         input logic [IDX_W-1:0] nidx, input logic [TAG_W-1:0] ntag,
                         input logic [WAY_NUM-1:0] nway, input bit expect_now,
                         input int exp_lat);
    int c0;
    int tries;
    logic [BEAT_W-1:0] d;
    logic [TAG_W+IDX_W-1:0] exp_addr;
    logic [WAY_NUM-1:0] exp_way;
    exp_addr = {tag, idx};
    exp_way  = ref_way(way);
    clear_logs();
    miss_req = 1'b1; miss_idx = idx; miss_tag = tag; miss_way = way;
    tries = 0;
    #1;
    while (!miss_ack && tries < 20) begin
      tick(); #1; tries++;
    end
    if (!miss_ack) begin
      check("ack_timeout", 64'd0, 64'd1);
      miss_req = 1'b0;
      return;
    end
    if (expect_now) check("ack_first_cycle", 64'(tries), 64'd0);
    c0 = cyc;
    tick();
    if (hold) begin
      miss_idx = nidx; miss_tag = ntag; miss_way = nway;
    end else begin
      miss_req = 1'b0;
    end
    for (int w = 0; w < rdy_wait; w++) begin
      mem_ack_val = stray && (w == 0);
      mem_ack_data = $urandom;
      #1;
      check("req_val", 64'(mem_req_val), 64'd1);
      check("req_addr", 64'(mem_req_addr), 64'(exp_addr));
      check("busy_no_ack", 64'(miss_ack), 64'd0);
      tick();
    end
    mem_ack_val = 1'b0;
    mem_req_rdy = 1'b1;
    #1;
    check("req_val_rdy", 64'(mem_req_val), 64'd1);
    check("req_addr_rdy", 64'(mem_req_addr), 64'(exp_addr));
    tick();
    mem_req_rdy = 1'b0;
    for (int b = 0; b < int'(BEATS); b++) begin
      for (int g = 0; g < gap; g++) begin
        #1;
        check("fill_no_ack", 64'(miss_ack), 64'd0);
        tick();
      end
      d = fixed ? BEAT_W'((b + 1) * 32'h11) : BEAT_W'($urandom);
      mem_ack_val = 1'b1;
      mem_ack_data = d;
      exp_q.push_back(d);
      tick();
      mem_ack_val = 1'b0;
    end
    #1;
    check("refill_done", 64'(refill_done), 64'd1);
    check("tag_we", 64'(tag_we), 64'd1);
    check("commit_no_ack", 64'(miss_ack), 64'd0);
    if (exp_lat >= 0) check("latency", 64'(cyc - c0), 64'(exp_lat));
    tick();
    #1;
    check("idle_not_busy", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(refill_done), 64'd0);
    check("n_data_we", 64'(we_beat.size()), 64'(BEATS));
    for (int i = 0; i < we_beat.size() && i < int'(BEATS); i++) begin
      check("we_beat", 64'(we_beat[i]), 64'(i));
      check("we_data", 64'(we_data[i]), 64'(exp_q[i]));
      check("we_way", 64'(we_way[i]), 64'(exp_way));
      check("we_idx", 64'(we_idx[i]), 64'(idx));
    end
    check("n_tag_we", 64'(tg_tag.size()), 64'd1);
    if (tg_tag.size() > 0) begin
      check("tag_val", 64'(tg_tag[0]), 64'(tag));
      check("tag_way", 64'(tg_way[0]), 64'(exp_way));
      check("tag_idx", 64'(tg_idx[0]), 64'(idx));
    end
    check("n_done", 64'(n_done), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    miss_req = 1'b0; miss_idx = '0; miss_tag = '0; miss_way = '0;
    mem_req_rdy = 1'b0; mem_ack_val = 1'b0; mem_ack_data = '0;
    tick(); tick();
    #1;
    check_all_zero("reset");
`ifdef L1_REFILL_ERR_CHK_EN
    check("err_reset", 64'(err), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Basic refill, minimum latency.
    do_miss(5'd5, 22'h2A5A5, 4'b0100, 0, 0, 1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0, 2 + BEATS);
    // Request backpressure and gapped beats.
    do_miss(5'd17, 22'h1234, 4'b0001, 3, 2, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, -1);
    // Second miss held throughout; accepted right after refill_done.
    do_miss(5'd3, 22'h3FFFF, 4'b1000, 1, 1, 1'b0, 1'b0, 1'b1, 5'd30, 22'h0ABCD, 4'b0010,
            1'b0, -1);
    do_miss(5'd30, 22'h0ABCD, 4'b0010, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 2 + BEATS);
    // Way normalisation.
    do_miss(5'd7, 22'h00077, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, -1);
    do_miss(5'd8, 22'h00088, 4'b0110, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, -1);
`ifdef L1_REFILL_ERR_CHK_EN
    check("err_multi_way", 64'(err), 64'd1);
`endif
    // Stray beat while the request is still pending.
    do_miss(5'd11, 22'h11111, 4'b0100, 2, 0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, -1);

    // Reset after two beats of a fill.
    clear_logs();
    miss_req = 1'b1; miss_idx = 5'd9; miss_tag = 22'h09999; miss_way = 4'b1000;
    #1;
    check("rst_case_ack", 64'(miss_ack), 64'd1);
    tick();
    miss_req = 1'b0; mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_ack_val = 1'b1; mem_ack_data = $urandom;
      tick();
    end
    mem_ack_val = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("mid_fill_reset");
    tick(); tick();
    check("rst_no_tag_we", 64'(tg_tag.size()), 64'd0);
    check("rst_no_done", 64'(n_done), 64'd0);
    rst = 1'b0;
    tick();
    do_miss(5'd9, 22'h09999, 4'b1000, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 2 + BEATS);

    // Randomized misses against the line model.
    for (int k = 0; k < 12; k++) begin
      do_miss(IDX_W'($urandom), TAG_W'($urandom), WAY_NUM'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom),
              1'b0, 1'b0, '0, '0, '0, 1'b0, -1);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/l1_refill_ctrl.md
Name: l1_refill_ctrl

Overview:
- Miss-handling engine for the L1 cache. Sits behind the L1 LRU/hit logic.
- Accepts one miss at a time: set index, tag and one-hot victim way chosen by the LRU.
- Issues a line read to the memory side, collects refill beats and writes them into the data array of the victim way.
- Writes tag and sets valid only after the whole line has arrived.

Parameters:
- WAY_NUM, 4, number of ways; width of one-hot way vectors.
- IDX_W, 5, set index width.
- TAG_W, 22, tag width.
- BEAT_W, 32, refill beat width in bits.
- BEATS, 4, beats per line; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high. All state cleared while high.
- miss_req  in  1  miss pending.
- miss_idx  in  IDX_W  set index of miss.
- miss_tag  in  TAG_W  tag of miss.
- miss_way  in  WAY_NUM  victim way vector from LRU.
- miss_ack  out  1  miss accepted this cycle.
- busy  out  1  refill in progress.
- mem_req_val  out  1  line read request valid.
- mem_req_addr  out  TAG_W+IDX_W  line address {tag,idx}.
- mem_req_rdy  in  1  memory accepts request.
- mem_ack_val  in  1  refill beat valid; no backpressure.
- mem_ack_data  in  BEAT_W  refill beat data.
- data_we  out  1  data array write strobe.
- data_way  out  WAY_NUM  one-hot write way.
- data_idx  out  IDX_W  write set.
- data_beat  out  log2(BEATS)  beat offset within the line.
- data_wdata  out  BEAT_W  write data.
- tag_we  out  1  tag/valid write strobe; sets valid for data_way.
- tag_wdata  out  TAG_W  tag to write; uses data_way and data_idx.
- refill_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, beat counter 0. All outputs 0, including the captured idx/tag/way registers.
- States:
  - IDLE: miss_ack = miss_req, combinational. On acceptance, capture idx, tag and way; go to REQ.
  - REQ: mem_req_val = 1, address held stable. On mem_req_rdy go to FILL. Beats arriving in REQ are ignored.
  - FILL: each mem_ack_val beat is registered. Next cycle: data_we = 1, data_beat = counter value at arrival, data_wdata = beat. Counter increments modulo BEATS. The beat taken with counter == BEATS-1 moves the FSM to COMMIT.
  - COMMIT (one cycle): the last beat's data_we is issued; tag_we = 1 and refill_done = 1 in the same cycle. Next state IDLE.
- busy = state != IDLE. miss_ack is always 0 when busy; the miss source must hold miss_req.
- A miss can be accepted in the cycle after refill_done; there is no bubble requirement.
- Way normalisation at capture:
  - miss_way == 0: use way 0.
  - Multiple bits set: keep only the lowest set bit.
- Minimum latency from miss_ack to refill_done, with rdy=1 and back-to-back beats: 2+BEATS cycles.
- Beat order is strictly incremental from 0; there is no critical-word-first support.
- Asserting rst mid-refill aborts immediately. tag_we has not fired, so the line stays invalid; partial data writes are harmless.
- mem_ack_val outside FILL is dropped silently.

Optional Feature:
- Macro: L1_REFILL_ERR_CHK_EN.
- Defined:
  - Adds output err (1 bit), sticky, cleared only by rst.
  - Set when an accepted miss_way is not one-hot, or when mem_ack_val is seen in IDLE or REQ.
  - Normalisation and drop behaviour are unchanged.
- Undefined: no err port and no checking logic.

Decomposition:
- Shared package l1_pkg holds:
  - state enum l1_refill_state_t {IDLE, REQ, FILL, COMMIT};
  - default constants for WAY_NUM, IDX_W, TAG_W, BEAT_W, BEATS;
  - a function lowest-one-hot(vec) returning bit 0 set for a zero input.
- No sub-module. FSM, counter and capture registers sit in one block.

Test Plan:
- Basic refill:
  - Stimulus: miss idx=5, tag=0x2A5A5, way=4'b0100; rdy=1; 4 consecutive beats 0x11..0x44.
  - Required: mem_req_addr={0x2A5A5,5}; data_we at beats 0..3 with that data; tag_we and refill_done 6 cycles after miss_ack.
- Backpressure and gaps:
  - Stimulus: rdy low 3 cycles; beats with 2-cycle gaps.
  - Required: mem_req_val and mem_req_addr held stable; exactly 4 data_we pulses; single refill_done.
- Busy blocking:
  - Stimulus: second miss_req held during a refill.
  - Required: miss_ack=0 until the cycle after refill_done; the second miss is then accepted with its own idx and tag.
- Way normalisation:
  - Stimulus: way=4'b0000, then a separate miss with way=4'b0110.
  - Required: data_way=4'b0001, then 4'b0010. With L1_REFILL_ERR_CHK_EN, err=1 after the second.
- Reset mid-FILL:
  - Stimulus: rst asserted after 2 beats.
  - Required: all outputs 0 immediately; tag_we never asserted; the next miss restarts at beat 0.
- Stray beat:
  - Stimulus: mem_ack_val in REQ.
  - Required: no data_we; the fill still takes 4 beats after rdy.
